// File: rtl/parc_core_muldiv_seq.sv
// X-stage sequencer for the iterative mul/div unit: issues the request, stalls X
// until the response fires, discards responses of squashed instructions, counts completions.
module parc_core_muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_val_Xhl,
  input  logic        is_muldiv_Xhl,
  input  logic [2:0]  muldiv_fn_Xhl,
  input  logic        squash_Xhl,
  input  logic        stall_Mhl,
  output logic        muldivreq_val,
  input  logic        muldivreq_rdy,
  output logic [2:0]  muldivreq_msg_fn_Xhl,
  input  logic        muldivresp_val,
  output logic        muldivresp_rdy,
  output logic        muldiv_mux_sel_Xhl,
  output logic        execute_mux_sel_Xhl,
  output logic        stall_muldiv_Xhl,
  output logic [15:0] muldiv_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        go;
  logic        resp_fire;

  assign go                   = inst_val_Xhl & is_muldiv_Xhl & ~squash_Xhl;
  assign muldivreq_msg_fn_Xhl = muldiv_fn_Xhl;
  assign muldiv_mux_sel_Xhl   = (muldiv_fn_Xhl == 3'd3) | (muldiv_fn_Xhl == 3'd4);
  assign execute_mux_sel_Xhl  = is_muldiv_Xhl & inst_val_Xhl;
  assign muldiv_count         = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    muldivreq_val    = 1'b0;
    muldivresp_rdy   = 1'b0;
    stall_muldiv_Xhl = 1'b0;
    resp_fire        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          muldivreq_val    = 1'b1;
          stall_muldiv_Xhl = 1'b1;
          state_d          = muldivreq_rdy ? ST_BUSY : ST_REQ;
        end
      end
      ST_REQ: begin
        muldivreq_val    = ~squash_Xhl;
        stall_muldiv_Xhl = ~squash_Xhl;
        if (squash_Xhl)         state_d = ST_IDLE;
        else if (muldivreq_rdy) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (squash_Xhl) begin
          // A response arriving with the squash is swallowed here; otherwise wait for it in DRAIN.
          muldivresp_rdy = muldivresp_val;
          state_d        = muldivresp_val ? ST_IDLE : ST_DRAIN;
        end else begin
          muldivresp_rdy   = ~stall_Mhl;
          resp_fire        = muldivresp_val & ~stall_Mhl;
          stall_muldiv_Xhl = ~resp_fire;
          if (resp_fire) begin
            state_d = ST_IDLE;
            count_d = count_q + 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        muldivresp_rdy   = 1'b1;
        stall_muldiv_Xhl = go;
        if (muldivresp_val) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/parc_core_muldiv_seq.md
# parc_core_muldiv_seq

Sequencer for the iterative integer multiply/divide unit in the X stage of the 5-stage PARCv2 pipeline. It issues the muldiv request, holds X (and everything upstream) until the result returns, and steers the X-stage result muxes. It also discards responses for squashed instructions and keeps a count of completed operations. It sits in the control unit, between the X-stage decode and the datapath muldiv val/rdy handshake.

## Interface
- No parameters. Fn encoding is fixed: MUL=0, DIV=1, DIVU=2, REM=3, REMU=4.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- inst_val_Xhl  in  1  valid instruction in X.
- is_muldiv_Xhl  in  1  X instruction is mul/div/divu/rem/remu.
- muldiv_fn_Xhl  in  3  fn code of the X instruction.
- squash_Xhl  in  1  kill the X instruction this cycle.
- stall_Mhl  in  1  downstream stall; X cannot hand a result to M.
- muldivreq_val  out  1  request valid to the muldiv unit.
- muldivreq_rdy  in  1  muldiv unit accepts a request.
- muldivreq_msg_fn_Xhl  out  3  fn forwarded to the unit.
- muldivresp_val  in  1  response valid from the unit.
- muldivresp_rdy  out  1  sequencer accepts the response.
- muldiv_mux_sel_Xhl  out  1  0 = result[31:0], 1 = result[63:32].
- execute_mux_sel_Xhl  out  1  1 = muldiv result feeds M.
- stall_muldiv_Xhl  out  1  stall request from this block, ORed into stall_Xhl/Dhl/Fhl.
- muldiv_count  out  16  completed (non-squashed) operations; wraps.

## Operation
- `go` = inst_val_Xhl & is_muldiv_Xhl & !squash_Xhl.
- Outputs are combinational from state and inputs unless stated otherwise. Only state and muldiv_count are registered.

States (2-bit):
- IDLE
  - On go: muldivreq_val=1 and stall_muldiv_Xhl=1.
  - go & rdy -> BUSY; go & !rdy -> REQ.
- REQ
  - muldivreq_val = !squash_Xhl; stall_muldiv_Xhl = !squash_Xhl.
  - squash -> IDLE, with no request issued. Otherwise rdy -> BUSY.
- BUSY
  - muldivresp_rdy = !stall_Mhl & !squash_Xhl.
  - stall_muldiv_Xhl = !(muldivresp_val & muldivresp_rdy) & !squash_Xhl.
  - Response fire -> IDLE and muldiv_count += 1.
  - squash & !muldivresp_val -> DRAIN.
  - squash & muldivresp_val -> muldivresp_rdy forced to 1, response discarded, -> IDLE, no count.
- DRAIN
  - muldivresp_rdy=1; muldivreq_val=0.
  - stall_muldiv_Xhl = go; a new muldiv waits and nothing is issued.
  - muldivresp_val -> IDLE.

Other rules:
- muldivreq_msg_fn_Xhl = muldiv_fn_Xhl in all states.
- muldiv_mux_sel_Xhl = 1 iff fn is REM (3) or REMU (4).
- execute_mux_sel_Xhl = is_muldiv_Xhl & inst_val_Xhl.
- A non-muldiv instruction in X never asserts stall_muldiv_Xhl, except in DRAIN, where it does not stall either because go=0.
- An undefined fn (5–7) is forwarded unchanged, with muldiv_mux_sel_Xhl=0.
- Reset forces IDLE and muldiv_count=0. After reset, every output is 0 given all-zero inputs.
- Reset mid-BUSY abandons the transaction. The muldiv unit is reset on the same reset.

## Timing
- Issue is the same cycle the instruction enters X, provided rdy is high.
- Stall length = unit latency + the cycles needed to win rdy.
- The result is presented in the fire cycle, and stall_muldiv_Xhl is 0 in that same cycle, so X->M advances at the next edge.
- There is no dead cycle: a back-to-back muldiv can issue in the cycle right after fire.
- Response with stall_Mhl=1: resp_rdy stays 0, the unit holds the result, and the stall persists until stall_Mhl drops.
- Squash and response in the same cycle: the response is consumed and discarded, with no count increment.
- At most one outstanding transaction. muldivreq_val is never asserted in BUSY or DRAIN.
- muldiv_count wraps from 16'hFFFF to 0.

## Test plan
- mul 6×7, unit latency 33, rdy=1:
  - stall_muldiv_Xhl high from cycle 0 through cycle 32 and low in the fire cycle (33).
  - execute_mux_sel=1, mux_sel=0, result[31:0]=42, muldiv_count=1.
- rem −7 % 2 (fn 3):
  - muldiv_mux_sel_Xhl=1, returned result[63:32]=0xFFFFFFFF.
  - Back-to-back divu 100/7 issues in the next cycle and returns 14.
- rdy held low 3 cycles:
  - muldivreq_val stays high in REQ for cycles 0–2 and the accept happens at cycle 3.
  - The request fn stays stable throughout.
- squash in BUSY at cycle 5:
  - stall drops immediately and the state goes to DRAIN.
  - A following mul 2×3 stalls with no request until the old response arrives, then issues and returns 6.
  - muldiv_count=1.
- Response arrives with stall_Mhl=1 for 4 cycles:
  - resp_rdy stays 0 and the stall holds.
  - Fire happens in the cycle stall_Mhl drops.
- Reset asserted mid-BUSY:
  - Next cycle state=IDLE, all outputs 0, muldiv_count=0.
  - A subsequent mul 3×5 returns 15.
